// File: rtl/plan_sigmoid_inv_if.sv
// Valid/ready stream bundle for plan_sigmoid_inv: activation y in, pre-activation x and sat out.
// master = surrounding logic driving y and consuming x; slave = the inverse block.
interface plan_sigmoid_inv_if #(
  parameter int unsigned DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] y;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] x;
  logic              sat;

  modport master (
    output in_valid, y, out_ready,
    input  in_ready, out_valid, x, sat
  );

  modport slave (
    input  in_valid, y, out_ready,
    output in_ready, out_valid, x, sat
  );
endinterface

// File: rtl/plan_sigmoid_inv.sv
// Inverse (logit) of the PLAN piecewise-linear sigmoid, two-stage valid/ready pipeline with sat counter.
// Define PLAN_SIGMOID_INV_SYMMETRIC_EN to fold y < 0.5 onto the upper half (negative x); otherwise such y clips to x=0.
module plan_sigmoid_inv #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned FRAC_BITS = 10,
  parameter int unsigned CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  plan_sigmoid_inv_if.slave  bus,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   sat_cnt
);

  // Fixed-point constants, all in units of 2^-FRAC_BITS.
  localparam logic [DATA_W-1:0] ONE     = DATA_W'(1) << FRAC_BITS;
  localparam logic [DATA_W-1:0] HALF    = ONE >> 1;
  localparam logic [DATA_W-1:0] T_MID   = ONE - (ONE >> 2);                // 0.75
  localparam logic [DATA_W-1:0] T_HI    = ONE - (ONE >> 4) - (ONE >> 6);   // 0.921875
  localparam logic [DATA_W-1:0] OFF_HI  = ONE - (ONE >> 3) - (ONE >> 5);   // 0.84375
  localparam logic [DATA_W-1:0] OFF_MID = HALF + (ONE >> 3);               // 0.625
  localparam logic [DATA_W-1:0] OFF_LO  = HALF;                            // 0.5
  localparam logic [DATA_W-1:0] M_SAT   = (ONE << 2) + ONE;                // 5.0

  typedef enum logic [2:0] {
    SEG_LO   = 3'd0,
    SEG_MID  = 3'd1,
    SEG_HI   = 3'd2,
    SEG_SAT  = 3'd3,
    SEG_CLIP = 3'd4
  } seg_e;

  logic              adv1_c;
  logic              adv2_c;

  logic              fold_c;
  logic [DATA_W-1:0] u_c;
  seg_e              seg_c;

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] y_q,        y_d;
  logic              fold_q,     fold_d;
  seg_e              seg_q,      seg_d;

  logic [DATA_W-1:0] u2_c;
  logic [DATA_W-1:0] m_c;
  logic [DATA_W-1:0] x_c;
  logic              sat_c;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] x_q,         x_d;
  logic              sat_q,       sat_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;

  // Pipeline advance: a stage may load when it is empty or its contents move on.
  assign adv2_c       = !out_valid_q || bus.out_ready;
  assign adv1_c       = !s1_valid_q  || adv2_c;
  assign bus.in_ready = adv1_c;

  // Fold and segment selection on the incoming activation.
  always_comb begin
    fold_c = 1'b0;
    u_c    = bus.y;
`ifdef PLAN_SIGMOID_INV_SYMMETRIC_EN
    if (bus.y < HALF) begin
      fold_c = 1'b1;
      u_c    = ONE - bus.y;
    end
`endif
    if (u_c >= ONE) begin
      seg_c = SEG_SAT;
    end else if (u_c >= T_HI) begin
      seg_c = SEG_HI;
    end else if (u_c >= T_MID) begin
      seg_c = SEG_MID;
    end else if (u_c >= HALF) begin
      seg_c = SEG_LO;
    end else begin
      seg_c = SEG_CLIP;
    end
  end

  // Stage 1 next state: capture y, fold and segment on an input transfer.
  always_comb begin
    s1_valid_d = s1_valid_q;
    y_d        = y_q;
    fold_d     = fold_q;
    seg_d      = seg_q;
    if (adv1_c) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        y_d    = bus.y;
        fold_d = fold_c;
        seg_d  = seg_c;
      end
    end
  end

  // Stage 2 datapath: slope is a power of two per segment, so each is a subtract and shift.
  always_comb begin
    u2_c  = fold_q ? (ONE - y_q) : y_q;
    m_c   = '0;
    sat_c = 1'b0;
    unique case (seg_q)
      SEG_SAT: begin
        m_c   = M_SAT;
        sat_c = 1'b1;
      end
      SEG_HI:  m_c = (u2_c - OFF_HI)  << 5;
      SEG_MID: m_c = (u2_c - OFF_MID) << 3;
      SEG_LO:  m_c = (u2_c - OFF_LO)  << 2;
      default: begin
        m_c   = '0;
        sat_c = 1'b1;
      end
    endcase
    x_c = fold_q ? (DATA_W'(0) - m_c) : m_c;
  end

  // Stage 2 next state and saturation counter.
  always_comb begin
    out_valid_d = out_valid_q;
    x_d         = x_q;
    sat_d       = sat_q;
    cnt_d       = cnt_q;
    if (adv2_c) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        x_d   = x_c;
        sat_d = sat_c;
      end
    end
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (out_valid_q && bus.out_ready && sat_q && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      y_q         <= '0;
      fold_q      <= 1'b0;
      seg_q       <= SEG_LO;
      out_valid_q <= 1'b0;
      x_q         <= '0;
      sat_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      y_q         <= y_d;
      fold_q      <= fold_d;
      seg_q       <= seg_d;
      out_valid_q <= out_valid_d;
      x_q         <= x_d;
      sat_q       <= sat_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.x         = x_q;
  assign bus.sat       = sat_q;
  assign sat_cnt       = cnt_q;

endmodule
